// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and slot control type for pipe_stage_reg.
// The skid slot is enabled by defining PIPE_SKID_EN at build time.
package pipe_stage_reg_pkg;

    localparam int PC_W        = 32;
    localparam int INST_W      = 32;
    localparam int PIPE_DATA_W = PC_W + INST_W;

    // Per-slot command; clear beats load beats drop.
    typedef struct packed {
        logic clear;
        logic load;
        logic drop;
    } slot_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+data register. Flush clears only the valid bit,
// so the data register keeps its contents.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  slot_ctrl_t        ctrl,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (ctrl.clear) begin
            valid <= 1'b0;
        end else if (ctrl.load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ctrl.drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_SKID_EN for a second (skid) slot and a registered in_ready_o.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_d;
    slot_ctrl_t        main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              xfer_in;
    logic              xfer_out;

    assign xfer_in  = in_valid_i && in_ready_o && !flush_i;
    assign xfer_out = main_valid && out_ready_i;

    // Main refills on transfer-out (from skid first, else from input) or when empty.
    always_comb begin
        main_ctrl       = '0;
        main_ctrl.clear = flush_i;
        main_ctrl.load  = xfer_out ? (skid_valid || xfer_in) : (!main_valid && xfer_in);
        main_ctrl.drop  = xfer_out;
        main_d          = skid_valid ? skid_data : in_data_i;
    end

    pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clock (clock),
        .reset (reset),
        .ctrl  (main_ctrl),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_data)
    );

`ifdef PIPE_SKID_EN
    slot_ctrl_t skid_ctrl;

    // Skid only catches a payload that arrives while main is stuck.
    always_comb begin
        skid_ctrl       = '0;
        skid_ctrl.clear = flush_i;
        skid_ctrl.load  = xfer_in && main_valid && !xfer_out;
        skid_ctrl.drop  = xfer_out;
    end

    pipe_slot #(.DATA_W(DATA_W)) u_skid (
        .clock (clock),
        .reset (reset),
        .ctrl  (skid_ctrl),
        .d     (in_data_i),
        .valid (skid_valid),
        .q     (skid_data)
    );

    assign in_ready_o = !skid_valid;
`else
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign in_ready_o = !main_valid || out_ready_i;
`endif

    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, replacing the bare write-enable PC/instruction latch between pipeline stages. It carries an arbitrary-width payload, supports flush (squash) from branch/exception logic, and counts back-pressure cycles for performance analysis. An optional skid slot breaks the combinational ready path so stages can be chained without long timing arcs. It sits between fetch→decode, decode→execute, and so on, one instance per boundary.

## Interface
- DATA_W, 64, payload width in bits; fetch→decode is {pc[31:0], inst[31:0]}.
- CNT_W, 32, width of the stall counter.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  squash all held entries this cycle.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  payload valid toward downstream.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  held payload.
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.

## Operation
- Transfer in: in_valid_i && in_ready_o at a clock edge, and flush_i=0.
- Transfer out: out_valid_o && out_ready_i at a clock edge.
- Main slot: holds out_data_o. It loads when empty, or on a transfer-out that occurs in the same cycle as a transfer-in.
- Payload order is strictly FIFO; no duplication, no loss except via flush.
- Flush:
  - flush_i=1 clears every valid bit at the edge.
  - Any transfer-in in that cycle is discarded.
  - Data registers keep their contents; downstream must ignore out_data_o when out_valid_o=0.
  - Flush has priority over simultaneous transfer-in and transfer-out.
- Stall counter: increments when out_valid_o && !out_ready_i. It saturates at all-ones, is unaffected by flush, and is cleared only by reset.
- Reset values:
  - out_valid_o=0, out_data_o=0, stall_cnt_o=0.
  - in_ready_o=1 in the first cycle after reset deasserts, in both configurations.
  - Skid slot valid=0 and data=0.
- Reset mid-operation discards all held payloads.

## Timing
- Latency: 1 cycle. A payload accepted at edge N appears on out_valid_o/out_data_o after edge N.
- Throughput: 1 payload per cycle when out_ready_i=1 continuously.
- Without skid: in_ready_o = !out_valid_o || out_ready_i (combinational from out_ready_i).
- With skid: in_ready_o = !skid_valid, driven directly from a flop.
  - Transfer-in while the main slot is full and no transfer-out occurs: the payload goes to the skid slot.
  - On transfer-out with the skid slot full: skid moves to main, and skid becomes free unless a new transfer-in refills it.
  - Capacity is 2; in_ready_o deasserts exactly when both slots are full.
- out_valid_o and out_data_o are always register outputs in both configurations.

## Configuration
- PIPE_SKID_EN defined: the skid slot is instantiated and in_ready_o is registered; capacity is 2.
- PIPE_SKID_EN undefined: single slot, combinational ready; capacity is 1.
- The port list is identical in both configurations.

## Structure
- Shared defines file holds default widths (PC_W=32, INST_W=32, PIPE_DATA_W=64) and the PIPE_SKID_EN switch location.
- Sub-module pipe_slot: one valid+data register with load, clear (flush) and reset. It is instantiated once for main and, under PIPE_SKID_EN, once for skid.
- Top level contains the handshake/steering logic and the stall counter.

## Test plan
- Reset, then idle: out_valid_o=0, out_data_o=0, in_ready_o=1, stall_cnt_o=0.
- Stream 0x1000_0001..0x1000_0010 with out_ready_i=1: outputs appear one cycle later, in order, with one payload per cycle.
- Send A=0xA, hold out_ready_i=0 for 5 cycles, keep offering B=0xB:
  - Without skid: B is not accepted until A drains.
  - With skid: B sits in skid, then in_ready_o=0.
  - In both: stall_cnt_o=5, then the output sequence is A, B.
- flush_i=1 in the same cycle as transfer-in of C=0xC while the stage holds D=0xD: next cycle out_valid_o=0, and neither C nor D is ever output.
- CNT_W=3, out_ready_i=0 with a valid payload held for 10 cycles: stall_cnt_o saturates at 7.
- Assert reset while two payloads are held (skid build): next cycle out_valid_o=0, in_ready_o=1, stall_cnt_o=0.
